// File: rtl/gates_selftest_seq_if.sv
// Connects the self-test sequencer to whatever controls it and to the gate block under test.
interface gates_selftest_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic [1:0]       y_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_seen;
    logic [1:0]       fail_vec;
    logic [1:0]       fail_y;

    // Controller side: requests runs, closes the loop through the gate block, reads status.
    modport master (
        output start, y_in,
        input  a, b, busy, done, pass, err_cnt, fail_seen, fail_vec, fail_y
    );

    // Sequencer side.
    modport slave (
        input  start, y_in,
        output a, b, busy, done, pass, err_cnt, fail_seen, fail_vec, fail_y
    );
endinterface

// File: rtl/gates_selftest_seq.sv
// Self-test sequencer for the NAND/NOR gate block.
// Walks a/b through 00,01,10,11 for NUM_PASSES passes, lets each vector settle for
// HOLD_CYCLES cycles, then checks y_in against {NOR, NAND} and records the result.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// APPLY  | drive a/b from vec_idx, load the settle counter
// SETTLE | hold the vector until the counter reaches zero
// CHECK  | compare y_in, update error count / first-failure capture
// DONE   | run finished; results held until the next start
module gates_selftest_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_PASSES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gates_selftest_seq_if.slave bus
);
    localparam int SW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_idx_q, vec_idx_d;
    logic [PW-1:0]    pass_idx_q, pass_idx_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [1:0]       fail_vec_q, fail_vec_d;
    logic [1:0]       fail_y_q, fail_y_d;
    logic [1:0]       exp_y;
    logic             mismatch;

    // State and datapath registers; reset lands everything in a quiet IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_idx_q   <= '0;
            pass_idx_q  <= '0;
            settle_q    <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
            fail_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            pass_idx_q  <= pass_idx_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
            fail_y_q    <= fail_y_d;
        end
    end

    // Next-state, vector walk and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        pass_idx_d  = pass_idx_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        err_cnt_d   = err_cnt_q;
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        fail_y_d    = fail_y_q;
        exp_y       = {~(a_q | b_q), ~(a_q & b_q)};
        mismatch    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_APPLY;
                    vec_idx_d   = '0;
                    pass_idx_d  = '0;
                    err_cnt_d   = '0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = '0;
                    fail_y_d    = '0;
                end
            end
            S_APPLY: begin
                a_d      = vec_idx_q[1];
                b_d      = vec_idx_q[0];
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_CHECK: begin
                // Case inequality so an X/Z from the gate block is flagged in simulation.
                mismatch = (bus.y_in !== exp_y);
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_vec_d  = {a_q, b_q};
                        fail_y_d    = bus.y_in;
                    end
                end
                if (vec_idx_q != 2'd3) begin
                    vec_idx_d = vec_idx_q + 2'd1;
                    state_d   = S_APPLY;
                end else if (pass_idx_q != PASS_LAST) begin
                    vec_idx_d  = '0;
                    pass_idx_d = pass_idx_q + PW'(1);
                    state_d    = S_APPLY;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with the state register.
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_seen = fail_seen_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.fail_y    = fail_y_q;

endmodule

// File: tb/tb_gates_selftest_seq.sv
// Bench for gates_selftest_seq: a fault-injecting gate model closes the loop on a/b -> y_in,
// the driver pushes per-cycle and per-run expectations, a negedge monitor pops and compares.
module tb_gates_selftest_seq;
    localparam int H     = 4;
    localparam int NP    = 3;
    localparam int CW    = 3;
    localparam int NV    = 4 * NP;
    localparam int VLEN  = H + 2;
    localparam int TOTAL = NV * VLEN;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gates_selftest_seq_if #(.CNT_W(CW)) bus();

    gates_selftest_seq #(
        .HOLD_CYCLES(H),
        .NUM_PASSES (NP),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Truth table of the healthy gate block: NOR is 1 only for 00, NAND is 0 only for 11.
    function automatic logic [1:0] gate_ref(input logic [1:0] v);
        return {v == 2'd0, v != 2'd3};
    endfunction

    logic [1:0] cur_mask;
    logic [1:0] masks [NV];
    assign bus.y_in = gate_ref({bus.a, bus.b}) ^ cur_mask;

    typedef struct {
        logic [1:0] ab;
        logic       busy;
        logic       done;
        logic       chkclr;
    } cyc_t;

    typedef struct {
        int         err;
        logic       seen;
        logic [1:0] fv;
        logic [1:0] fy;
        logic       pass;
    } res_t;

    cyc_t cq[$];
    res_t rq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle output trajectory plus one result record per rising done.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        cyc_t c;
        res_t r;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            check("ab", int'({bus.a, bus.b}), int'(c.ab));
            check("busy", int'(bus.busy), int'(c.busy));
            check("done", int'(bus.done), int'(c.done));
            if (c.chkclr) begin
                check("clr_err_cnt", int'(bus.err_cnt), 0);
                check("clr_fail_seen", int'(bus.fail_seen), 0);
                check("clr_fail_vec", int'(bus.fail_vec), 0);
                check("clr_fail_y", int'(bus.fail_y), 0);
                check("clr_pass", int'(bus.pass), 0);
            end
        end
        if (bus.done && !done_prev) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                check("err_cnt", int'(bus.err_cnt), r.err);
                check("fail_seen", int'(bus.fail_seen), int'(r.seen));
                check("fail_vec", int'(bus.fail_vec), int'(r.fv));
                check("fail_y", int'(bus.fail_y), int'(r.fy));
                check("pass", int'(bus.pass), int'(r.pass));
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no run result pending (t=%0t)", $time);
            end
        end
        done_prev = bus.done;
    end

    logic [1:0] last_ab;
    logic       last_done;

    function automatic res_t predict();
        res_t r;
        int raw;
        int first;
        raw   = 0;
        first = -1;
        for (int i = 0; i < NV; i++) begin
            if (masks[i] != 2'b00) begin
                raw++;
                if (first < 0) first = i;
            end
        end
        r.err  = (raw > ERR_MAX) ? ERR_MAX : raw;
        r.seen = (first >= 0);
        r.fv   = (first >= 0) ? 2'(first % 4) : 2'b00;
        r.fy   = (first >= 0) ? (gate_ref(2'(first % 4)) ^ masks[first]) : 2'b00;
        r.pass = (raw == 0);
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            c.ab = last_ab; c.busy = 1'b0; c.done = last_done; c.chkclr = 1'b0;
            cq.push_back(c);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_a", int'(bus.a), 0);
        check("rst_b", int'(bus.b), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pass", int'(bus.pass), 0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
        check("rst_fail_seen", int'(bus.fail_seen), 0);
        check("rst_fail_vec", int'(bus.fail_vec), 0);
        check("rst_fail_y", int'(bus.fail_y), 0);
    endtask

    // One run: start sampled at edge m=0; vector j occupies edges j*VLEN+1 .. (j+1)*VLEN.
    // pulse_m: an extra start pulse for edge pulse_m (mid-run, must be ignored).
    // b2b: keep start high across the end so the next run starts on the edge after DONE.
    // rst_m: assert rst_n between edges after edge rst_m and abandon the run (-1 = none).
    task automatic run(input int pulse_m, input bit b2b, input int rst_m);
        cyc_t c;
        rq.push_back(predict());
        bus.start = 1'b1;
        for (int m = 0; m <= TOTAL; m++) begin
            @(posedge clk);
            #1;
            if (m == 0) begin
                c.ab = last_ab; c.busy = 1'b1; c.done = 1'b0; c.chkclr = 1'b1;
            end else if (m < TOTAL) begin
                c.ab = 2'(((m - 1) / VLEN) % 4); c.busy = 1'b1; c.done = 1'b0; c.chkclr = 1'b0;
            end else begin
                c.ab = 2'd3; c.busy = 1'b0; c.done = 1'b1; c.chkclr = 1'b0;
            end
            cq.push_back(c);
            cur_mask  = (m < TOTAL) ? masks[m / VLEN] : 2'b00;
            bus.start = ((m + 1) == pulse_m) || (b2b && (m + 1) >= TOTAL);
            if (m == rst_m) begin
                bus.start = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                cq.delete();
                rq.delete();
                cur_mask = 2'b00;
                #1;
                rst_n = 1'b1;
                last_ab   = 2'b00;
                last_done = 1'b0;
                return;
            end
        end
        last_ab   = 2'b11;
        last_done = 1'b1;
    endtask

    task automatic fill_masks(input int mode);
        for (int i = 0; i < NV; i++) begin
            case (mode)
                0: masks[i] = 2'b00;                                      // healthy
                1: masks[i] = gate_ref(2'(i % 4)) & 2'b01;                // y[0] stuck 0
                2: masks[i] = ~gate_ref(2'(i % 4)) & 2'b10;               // y[1] stuck 1
                3: masks[i] = gate_ref(2'(i % 4));                        // y constant 00
                default: masks[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            endcase
        end
    endtask

    initial begin
        bool_init: begin
            bit b2b;
            bus.start = 1'b0;
            cur_mask  = 2'b00;
            last_ab   = 2'b00;
            last_done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check_reset_outputs();
            rst_n = 1'b1;
            idle_cycles(2);

            for (int mode = 0; mode < 4; mode++) begin
                fill_masks(mode);
                run(0, 1'b0, -1);
                idle_cycles(3);
            end

            for (int k = 0; k < 8; k++) begin
                fill_masks(4);
                b2b = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
                run(int'($urandom_range(1, TOTAL - 1)), b2b, -1);
                if (!b2b) idle_cycles(int'($urandom_range(1, 4)));
            end

            // Start pulse while vector 2 is settling must not disturb the run.
            fill_masks(4);
            run(2 * VLEN + 3, 1'b0, -1);
            idle_cycles(2);

            // Reset in the middle of a run, after a failure has been captured.
            fill_masks(4);
            masks[0] = 2'b01;
            run(0, 1'b0, VLEN + 2);
            idle_cycles(4);

            fill_masks(0);
            run(0, 1'b0, -1);
            idle_cycles(3);

            check("results_drained", rq.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

endmodule

// File: doc/gates_selftest_seq.md
Name: gates_selftest_seq

Overview:
Self-test sequencer that sits directly upstream of the NAND/NOR gate block and drives its a/b inputs. It also receives the gate block's 2-bit y output and checks it. On start it applies all four input vectors (00, 01, 10, 11) for a programmable number of passes, holds each vector for a settle window, then compares y against the expected {NOR, NAND}. It reports done/pass status, a saturating error count and a capture of the first failing vector.

Parameters:
HOLD_CYCLES, 4, settle cycles a vector is held before sampling y (legal range >= 1)
NUM_PASSES, 1, full 4-vector passes per run (legal range >= 1)
CNT_W, 8, width of the error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled in IDLE or DONE only
a  output  1  gate input a, registered
b  output  1  gate input b, registered
y_in  input  2  gate output; [1]=NOR, [0]=NAND
busy  output  1  high from the first APPLY through the last CHECK
done  output  1  level, high in DONE
pass  output  1  valid in DONE; 1 iff err_cnt==0
err_cnt  output  CNT_W  mismatch count, saturating
fail_seen  output  1  at least one mismatch captured this run
fail_vec  output  2  {a,b} of the first mismatch
fail_y  output  2  y_in sampled at the first mismatch

Behaviour:
- One clock domain: clk.
- Reset is asynchronous and active-low (rst_n). It takes effect immediately, including mid-run.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_seen=0, fail_vec=0, fail_y=0. State=IDLE, vec_idx=0, pass_idx=0, settle counter=0.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: start=1 -> APPLY. On that edge: clear err_cnt, fail_seen, fail_vec, fail_y, done, pass; set vec_idx=0, pass_idx=0.
- APPLY (1 cycle): a<=vec_idx[1], b<=vec_idx[0]; settle counter<=HOLD_CYCLES-1; -> SETTLE.
- SETTLE (exactly HOLD_CYCLES cycles): decrement the counter each cycle; leave for CHECK on the cycle the counter is 0.
- CHECK (1 cycle):
  - expected = {~(a|b), ~(a&b)}.
  - Mismatch if y_in !== expected (bitwise; X/Z on y_in counts as a mismatch in simulation).
  - On mismatch: err_cnt+1, saturating at 2^CNT_W-1.
  - On mismatch with fail_seen=0: capture fail_vec={a,b}, fail_y=y_in, and set fail_seen=1.
  - Next state:
    - vec_idx<3: vec_idx+1 -> APPLY.
    - vec_idx==3 and pass_idx<NUM_PASSES-1: vec_idx=0, pass_idx+1 -> APPLY.
    - Otherwise -> DONE.
- DONE: done=1, busy=0, pass=(err_cnt==0). a/b hold the last vector (1,1). start=1 -> behaves exactly as start in IDLE (clears and restarts).
- start is ignored while busy. A start held high continuously restarts a run immediately on every entry to DONE; done is then high for one cycle.
- Timing:
  - Per vector: H+2 clock edges (H=HOLD_CYCLES).
  - Edge at which start is sampled to edge entering DONE: 4*NUM_PASSES*(H+2).
  - a/b change on the edge entering SETTLE.
  - y_in is sampled at the end of CHECK, i.e. H+1 cycles after a/b change.
- a/b are registered directly from flops; there is no combinational path from start or y_in to any output.
- Outputs other than done/busy/pass hold their values across DONE until the next start or reset.

Test Plan:
1. Correct NAND/NOR model on y_in, H=4, NUM_PASSES=1, 1-cycle start pulse -> a,b = 00,01,10,11, each held 6 cycles. done rises 24 edges after the start edge; pass=1, err_cnt=0, fail_seen=0.
2. y_in[0] stuck at 0, H=4 -> mismatches at 00,01,10. err_cnt=3, fail_seen=1, fail_vec=2'b00, fail_y=2'b10, pass=0.
3. NUM_PASSES=3, y_in[1] stuck at 1 -> mismatches at 01,10,11 each pass. err_cnt=9, fail_vec=2'b01, fail_y=2'b11, done at edge 72.
4. CNT_W=3, NUM_PASSES=4, y_in=2'b00 constant -> 3 mismatches per pass (12 raw). err_cnt saturates at 7, no wrap; pass=0.
5. start pulsed during SETTLE of vector 2 -> ignored, run finishes normally. start pulsed in DONE -> err_cnt/fail_* cleared on that edge, done=0, new run from vector 00.
6. rst_n driven low mid-SETTLE (asynchronously, between edges) -> all outputs go to reset values immediately, without waiting for an edge. After rst_n returns high, a/b stay 00 and busy=0 until the next start.
